// File: rtl/usb2_pkg.sv
// Shared definitions for the usb 2.0 external endpoint buffer clients.
// Holds the loopback FSM state encoding and the buffer geometry constants.
package usb2_pkg;

  localparam int unsigned USB2_BUF_ADDR_W = 9;
  localparam int unsigned USB2_BUF_LEN_W  = 10;
  localparam int unsigned USB2_MAX_PKT    = 512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    COPY    = 3'd2,
    COMMIT  = 3'd3,
    ARM     = 3'd4
  } lb_state_e;

endpackage

// File: rtl/usb2_ext_loopback.sv
// Loopback client for the usb 2.0 core's external endpoint buffers.
// Reads each OUT packet, writes it back into the IN buffer, commits it,
// then re-arms the OUT buffer.
// Ports:
//   ext_clk, reset_n         clock, asynchronous active-low reset
//   enable, stat_configured  start qualifiers (enable sampled in IDLE only)
//   buf_out_*                OUT buffer read side (q has 1-cycle latency)
//   buf_in_*                 IN buffer write / commit side
//   busy                     high whenever the FSM is not IDLE
// Optional: define USB2_LOOPBACK_STATS_EN to add stat_pkt_cnt / stat_byte_cnt.
module usb2_ext_loopback
  import usb2_pkg::*;
#(
  parameter int unsigned MAX_LEN = USB2_MAX_PKT,
  parameter int unsigned ADDR_W  = USB2_BUF_ADDR_W,
  parameter int unsigned LEN_W   = USB2_BUF_LEN_W
) (
  input  logic              ext_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              stat_configured,
  input  logic              buf_out_hasdata,
  input  logic [LEN_W-1:0]  buf_out_len,
  output logic [ADDR_W-1:0] buf_out_addr,
  input  logic [7:0]        buf_out_q,
  output logic              buf_out_arm,
  input  logic              buf_out_arm_ack,
  input  logic              buf_in_ready,
  output logic [ADDR_W-1:0] buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  output logic              buf_in_commit,
  output logic [LEN_W-1:0]  buf_in_commit_len,
  input  logic              buf_in_commit_ack,
  output logic              busy
`ifdef USB2_LOOPBACK_STATS_EN
  ,
  output logic [15:0]       stat_pkt_cnt,
  output logic [31:0]       stat_byte_cnt
`endif
);

  lb_state_e         state, state_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [LEN_W-1:0]  rd, rd_n;
  logic [ADDR_W-1:0] in_addr_n;
  logic              wren_n, commit_n, arm_n, busy_n;
  logic [LEN_W-1:0]  commit_len_n;
  logic [LEN_W-1:0]  len_clamped;

  assign len_clamped = (buf_out_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : buf_out_len;

  // Read address is the live read counter; the wide counter keeps rd == MAX_LEN distinct.
  assign buf_out_addr = ADDR_W'(rd);
  // Write data is the OUT read data of the previous address; wren/addr are delayed to match.
  assign buf_in_data  = buf_out_q;

  // State and registered outputs.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      len               <= '0;
      rd                <= '0;
      buf_in_addr       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      buf_out_arm       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      len               <= len_n;
      rd                <= rd_n;
      buf_in_addr       <= in_addr_n;
      buf_in_wren       <= wren_n;
      buf_in_commit     <= commit_n;
      buf_in_commit_len <= commit_len_n;
      buf_out_arm       <= arm_n;
      busy              <= busy_n;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n      = state;
    len_n        = len;
    rd_n         = rd;
    in_addr_n    = '0;
    wren_n       = 1'b0;
    commit_n     = 1'b0;
    commit_len_n = '0;
    arm_n        = 1'b0;

    case (state)
      IDLE: begin
        rd_n = '0;
        if (enable && stat_configured && buf_out_hasdata) begin
          state_n = WAIT_IN;
          len_n   = len_clamped;
        end
      end
      WAIT_IN: begin
        if (buf_in_ready) begin
          if (len == '0) begin
            state_n      = COMMIT;
            commit_n     = 1'b1;
            commit_len_n = len;
          end else begin
            state_n = COPY;
          end
        end
      end
      COPY: begin
        // Once rd reaches len the registered final write is on the bus this cycle.
        if (rd < len) begin
          rd_n      = rd + LEN_W'(1);
          wren_n    = 1'b1;
          in_addr_n = ADDR_W'(rd);
        end else begin
          state_n      = COMMIT;
          commit_n     = 1'b1;
          commit_len_n = len;
        end
      end
      COMMIT: begin
        if (buf_in_commit_ack) begin
          state_n = ARM;
          arm_n   = 1'b1;
        end else begin
          commit_n     = 1'b1;
          commit_len_n = len;
        end
      end
      ARM: begin
        if (buf_out_arm_ack) begin
          state_n = IDLE;
          rd_n    = '0;
        end else begin
          arm_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Losing configuration abandons the packet; the core flushes its own buffers.
    if (state != IDLE && !stat_configured) begin
      state_n      = IDLE;
      rd_n         = '0;
      in_addr_n    = '0;
      wren_n       = 1'b0;
      commit_n     = 1'b0;
      commit_len_n = '0;
      arm_n        = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

`ifdef USB2_LOOPBACK_STATS_EN
  // Packet/byte counters advance on each accepted commit; aborts leave them alone.
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkt_cnt  <= '0;
      stat_byte_cnt <= '0;
    end else if (state == COMMIT && buf_in_commit_ack && stat_configured) begin
      stat_pkt_cnt  <= stat_pkt_cnt + 16'd1;
      stat_byte_cnt <= stat_byte_cnt + 32'(len);
    end
  end
`else
  // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_usb2_ext_loopback.sv
// Directed testbench for usb2_ext_loopback: models the OUT buffer read port,
// logs every IN write / handshake, and checks each scenario inline.
module tb_usb2_ext_loopback;
  import usb2_pkg::*;

  localparam int unsigned AW = USB2_BUF_ADDR_W;
  localparam int unsigned LW = USB2_BUF_LEN_W;
  localparam int unsigned LOG_N = 2048;

  logic          ext_clk = 1'b0;
  logic          reset_n;
  logic          enable, stat_configured, buf_out_hasdata;
  logic [LW-1:0] buf_out_len;
  logic [AW-1:0] buf_out_addr;
  logic [7:0]    buf_out_q;
  logic          buf_out_arm, buf_out_arm_ack;
  logic          buf_in_ready;
  logic [AW-1:0] buf_in_addr;
  logic [7:0]    buf_in_data;
  logic          buf_in_wren, buf_in_commit;
  logic [LW-1:0] buf_in_commit_len;
  logic          buf_in_commit_ack;
  logic          busy;
`ifdef USB2_LOOPBACK_STATS_EN
  logic [15:0]   stat_pkt_cnt;
  logic [31:0]   stat_byte_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 ext_clk = ~ext_clk;

  usb2_ext_loopback dut (
    .ext_clk           (ext_clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .stat_configured   (stat_configured),
    .buf_out_hasdata   (buf_out_hasdata),
    .buf_out_len       (buf_out_len),
    .buf_out_addr      (buf_out_addr),
    .buf_out_q         (buf_out_q),
    .buf_out_arm       (buf_out_arm),
    .buf_out_arm_ack   (buf_out_arm_ack),
    .buf_in_ready      (buf_in_ready),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .busy              (busy)
`ifdef USB2_LOOPBACK_STATS_EN
    ,
    .stat_pkt_cnt      (stat_pkt_cnt),
    .stat_byte_cnt     (stat_byte_cnt)
`endif
  );

  // OUT buffer: synchronous read, one-cycle latency.
  logic [7:0] out_mem [0:511];
  always @(posedge ext_clk) buf_out_q <= out_mem[buf_out_addr];

  // Activity log.
  logic [AW-1:0] wr_addr_log [0:LOG_N-1];
  logic [7:0]    wr_data_log [0:LOG_N-1];
  int wr_cnt = 0, busy_cyc = 0, commit_cyc = 0, commit_acc = 0;
  int arm_cyc = 0, arm_acc = 0, both_cyc = 0;

  always @(posedge ext_clk) begin
    if (buf_in_wren === 1'b1) begin
      if (wr_cnt < LOG_N) begin
        wr_addr_log[wr_cnt] <= buf_in_addr;
        wr_data_log[wr_cnt] <= buf_in_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (buf_in_commit === 1'b1) commit_cyc <= commit_cyc + 1;
    if (buf_in_commit === 1'b1 && buf_in_commit_ack) commit_acc <= commit_acc + 1;
    if (buf_out_arm === 1'b1) arm_cyc <= arm_cyc + 1;
    if (buf_out_arm === 1'b1 && buf_out_arm_ack) arm_acc <= arm_acc + 1;
    if (buf_in_commit === 1'b1 && buf_out_arm === 1'b1) both_cyc <= both_cyc + 1;
  end

  // Loads pattern (i + seed) and presents a packet for one cycle.
  task automatic start_pkt(input int len, input int seed);
    for (int i = 0; i < 512; i++) out_mem[i] = 8'(i + seed);
    buf_out_len     = LW'(len);
    buf_out_hasdata = 1'b1;
    @(negedge ext_clk);
    buf_out_hasdata = 1'b0;
  endtask

  // Plays the core's handshakes; reports commit length and handshake steadiness.
  task automatic finish_pkt(input int cdly, input int adly,
                            output logic [LW-1:0] clen, output bit ok, output bit steady);
    int t;
    ok = 1'b1; steady = 1'b1; clen = '0; t = 0;
    while (buf_in_commit !== 1'b1 && t < 2000) begin @(negedge ext_clk); t++; end
    if (buf_in_commit !== 1'b1) begin ok = 1'b0; return; end
    clen = buf_in_commit_len;
    for (int i = 0; i < cdly; i++) begin
      if (buf_in_commit !== 1'b1 || buf_in_commit_len !== clen || buf_out_arm !== 1'b0) steady = 1'b0;
      @(negedge ext_clk);
    end
    buf_in_commit_ack = 1'b1;
    @(negedge ext_clk);
    buf_in_commit_ack = 1'b0;
    t = 0;
    while (buf_out_arm !== 1'b1 && t < 50) begin @(negedge ext_clk); t++; end
    if (buf_out_arm !== 1'b1) begin ok = 1'b0; return; end
    for (int i = 0; i < adly; i++) begin
      if (buf_out_arm !== 1'b1 || buf_in_commit !== 1'b0) steady = 1'b0;
      @(negedge ext_clk);
    end
    buf_out_arm_ack = 1'b1;
    @(negedge ext_clk);
    buf_out_arm_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; stat_configured = 1'b1; buf_out_hasdata = 1'b0;
    buf_out_len = '0; buf_out_arm_ack = 1'b0; buf_in_ready = 1'b1; buf_in_commit_ack = 1'b0;
    for (int i = 0; i < 512; i++) out_mem[i] = 8'h00;
    repeat (3) @(negedge ext_clk);
    n_cmp++;
    if ({busy, buf_in_wren, buf_in_commit, buf_out_arm} !== 4'b0 || buf_out_addr !== '0 ||
        buf_in_addr !== '0 || buf_in_commit_len !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b wren=%b commit=%b arm=%b out_addr=%0d in_addr=%0d clen=%0d, want all 0",
               busy, buf_in_wren, buf_in_commit, buf_out_arm, buf_out_addr, buf_in_addr, buf_in_commit_len);
    end
    reset_n = 1'b1;
    @(negedge ext_clk);
  endtask

  task automatic test_basic_64();
    int w0 = wr_cnt, b0 = busy_cyc, a0 = arm_acc, c0 = commit_acc, bad = 0;
    logic [LW-1:0] clen; bit ok, steady;
    start_pkt(64, 0);
    finish_pkt(0, 0, clen, ok, steady);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: handshake not reached"); end
    n_cmp++; if (wr_cnt - w0 != 64) begin n_err++; $display("FAIL basic_wr_count: got %0d want 64", wr_cnt - w0); end
    for (int i = 0; i < 64; i++)
      if (wr_addr_log[w0+i] !== AW'(i) || wr_data_log[w0+i] !== 8'(i)) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL basic_wr_data: %0d bad entries want 0", bad); end
    n_cmp++; if (clen !== LW'(64)) begin n_err++; $display("FAIL basic_commit_len: got %0d want 64", clen); end
    n_cmp++; if (commit_acc - c0 != 1 || arm_acc - a0 != 1) begin
      n_err++; $display("FAIL basic_handshakes: commits %0d arms %0d want 1 1", commit_acc - c0, arm_acc - a0); end
    // WAIT_IN 1 + COPY 65 + COMMIT 1 + ARM 1
    n_cmp++; if (busy_cyc - b0 != 68) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 68", busy_cyc - b0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_zero_len();
    int w0 = wr_cnt, a0 = arm_acc;
    logic [LW-1:0] clen; bit ok, steady;
    start_pkt(0, 9);
    finish_pkt(0, 0, clen, ok, steady);
    n_cmp++; if (!ok || wr_cnt - w0 != 0) begin n_err++; $display("FAIL zlp_no_write: ok=%b writes %0d want 1 0", ok, wr_cnt - w0); end
    n_cmp++; if (clen !== '0) begin n_err++; $display("FAIL zlp_commit_len: got %0d want 0", clen); end
    n_cmp++; if (arm_acc - a0 != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL zlp_arm_idle: arms %0d busy %b want 1 0", arm_acc - a0, busy); end
  endtask

  task automatic test_clamp();
    int w0 = wr_cnt;
    logic [LW-1:0] clen; bit ok, steady;
    start_pkt(700, 3);
    enable = 1'b0;   // dropping enable mid-packet must not stop it
    finish_pkt(2, 1, clen, ok, steady);
    enable = 1'b1;
    n_cmp++; if (!ok || wr_cnt - w0 != 512) begin n_err++; $display("FAIL clamp_wr_count: ok=%b got %0d want 512", ok, wr_cnt - w0); end
    n_cmp++; if (wr_addr_log[w0+511] !== AW'(511) || wr_data_log[w0+511] !== 8'(511 + 3)) begin
      n_err++; $display("FAIL clamp_last_write: addr %0d data %h want 511 %h", wr_addr_log[w0+511], wr_data_log[w0+511], 8'(514)); end
    n_cmp++; if (clen !== LW'(512)) begin n_err++; $display("FAIL clamp_commit_len: got %0d want 512", clen); end
  endtask

  task automatic test_wait_ready();
    int w0 = wr_cnt, bad = 0;
    logic [LW-1:0] clen; bit ok, steady;
    buf_in_ready = 1'b0;
    start_pkt(8, 40);
    for (int i = 0; i < 20; i++) begin
      if (buf_out_addr !== '0 || buf_in_wren !== 1'b0) bad++;
      @(negedge ext_clk);
    end
    n_cmp++; if (bad != 0 || wr_cnt != w0) begin n_err++; $display("FAIL ready_hold: %0d bad cycles, %0d writes, want 0 0", bad, wr_cnt - w0); end
    buf_in_ready = 1'b1;
    @(negedge ext_clk);
    n_cmp++; if (buf_out_addr !== '0 || buf_in_wren !== 1'b0) begin
      n_err++; $display("FAIL ready_first_copy: addr %0d wren %b want 0 0", buf_out_addr, buf_in_wren); end
    @(negedge ext_clk);
    n_cmp++; if (buf_out_addr !== AW'(1) || buf_in_wren !== 1'b1 || buf_in_addr !== '0 || buf_in_data !== 8'd40) begin
      n_err++; $display("FAIL ready_first_write: addr %0d wren %b waddr %0d data %h want 1 1 0 28",
                        buf_out_addr, buf_in_wren, buf_in_addr, buf_in_data); end
    finish_pkt(0, 0, clen, ok, steady);
    n_cmp++; if (!ok || wr_cnt - w0 != 8 || clen !== LW'(8)) begin
      n_err++; $display("FAIL ready_complete: ok=%b writes %0d clen %0d want 1 8 8", ok, wr_cnt - w0, clen); end
  endtask

  task automatic test_slow_acks();
    int cc0 = commit_cyc, ac0 = arm_cyc, bh0 = both_cyc;
    logic [LW-1:0] clen; bit ok, steady;
    start_pkt(5, 100);
    finish_pkt(10, 5, clen, ok, steady);
    n_cmp++; if (!ok || !steady) begin n_err++; $display("FAIL slow_steady: ok=%b steady=%b want 1 1", ok, steady); end
    n_cmp++; if (commit_cyc - cc0 != 11 || arm_cyc - ac0 != 6) begin
      n_err++; $display("FAIL slow_hold_cycles: commit %0d arm %0d want 11 6", commit_cyc - cc0, arm_cyc - ac0); end
    n_cmp++; if (both_cyc != bh0) begin n_err++; $display("FAIL slow_overlap: %0d cycles both high want 0", both_cyc - bh0); end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt, cc0 = commit_cyc, ac0 = arm_cyc, t = 0;
    start_pkt(100, 7);
    while (buf_out_addr !== AW'(50) && t < 200) begin @(negedge ext_clk); t++; end
    n_cmp++; if (buf_out_addr !== AW'(50)) begin n_err++; $display("FAIL abort_reach: addr %0d want 50", buf_out_addr); end
    stat_configured = 1'b0;
    @(negedge ext_clk);
    n_cmp++; if ({busy, buf_in_wren, buf_in_commit, buf_out_arm} !== 4'b0 || buf_out_addr !== '0) begin
      n_err++; $display("FAIL abort_idle: busy %b wren %b commit %b arm %b addr %0d want 0",
                        busy, buf_in_wren, buf_in_commit, buf_out_arm, buf_out_addr); end
    repeat (10) @(negedge ext_clk);
    n_cmp++; if (commit_cyc != cc0 || arm_cyc != ac0 || wr_cnt - w0 != 50) begin
      n_err++; $display("FAIL abort_no_requests: commit %0d arm %0d writes %0d want 0 0 50",
                        commit_cyc - cc0, arm_cyc - ac0, wr_cnt - w0); end
    stat_configured = 1'b1;
    @(negedge ext_clk);
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, bad = 0;
    logic [LW-1:0] c1, c2; bit ok1, ok2, s;
`ifdef USB2_LOOPBACK_STATS_EN
    logic [15:0] p0 = stat_pkt_cnt;
    logic [31:0] y0 = stat_byte_cnt;
`endif
    start_pkt(10, 20);
    finish_pkt(0, 0, c1, ok1, s);
    start_pkt(10, 60);
    finish_pkt(1, 1, c2, ok2, s);
    for (int i = 0; i < 10; i++) begin
      if (wr_data_log[w0+i] !== 8'(20 + i) || wr_addr_log[w0+i] !== AW'(i)) bad++;
      if (wr_data_log[w0+10+i] !== 8'(60 + i) || wr_addr_log[w0+10+i] !== AW'(i)) bad++;
    end
    n_cmp++; if (!ok1 || !ok2 || wr_cnt - w0 != 20 || bad != 0) begin
      n_err++; $display("FAIL b2b_data: ok %b%b writes %0d bad %0d want 11 20 0", ok1, ok2, wr_cnt - w0, bad); end
    n_cmp++; if (c1 !== LW'(10) || c2 !== LW'(10)) begin n_err++; $display("FAIL b2b_commit_len: %0d %0d want 10 10", c1, c2); end
`ifdef USB2_LOOPBACK_STATS_EN
    n_cmp++; if (stat_pkt_cnt - p0 !== 16'd2 || stat_byte_cnt - y0 !== 32'd20) begin
      n_err++; $display("FAIL stats_delta: pkts %0d bytes %0d want 2 20", stat_pkt_cnt - p0, stat_byte_cnt - y0); end
`endif
  endtask

  task automatic test_async_reset();
    start_pkt(30, 1);
    repeat (10) @(negedge ext_clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({busy, buf_in_wren, buf_in_commit, buf_out_arm} !== 4'b0 || buf_out_addr !== '0 || buf_in_addr !== '0) begin
      n_err++; $display("FAIL async_reset: busy %b wren %b commit %b arm %b addr %0d want 0",
                        busy, buf_in_wren, buf_in_commit, buf_out_arm, buf_out_addr); end
`ifdef USB2_LOOPBACK_STATS_EN
    n_cmp++; if (stat_pkt_cnt !== '0 || stat_byte_cnt !== '0) begin
      n_err++; $display("FAIL stats_reset: %0d %0d want 0 0", stat_pkt_cnt, stat_byte_cnt); end
`endif
    @(negedge ext_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge ext_clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_64();
    test_zero_len();
    test_clamp();
    test_wait_ready();
    test_slow_acks();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb2_ext_loopback.md
Name: usb2_ext_loopback

Overview:
- Application-side client of the usb 2.0 core's external endpoint buffer interface, clocked by ext_clk.
- Drives the opposite direction of every buf_in_*/buf_out_* signal the core exports: consumes OUT packets and echoes each one back as an IN packet.
- Serves as the bring-up/loopback client for usb2_top and as a reference consumer for application logic.

Parameters:
- MAX_LEN, 512, largest packet in bytes; lengths above this are clamped.
- ADDR_W, 9, buffer byte address width.
- LEN_W, 10, packet length width.

Ports:
- ext_clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  loopback permitted; sampled only in IDLE.
- stat_configured  in  1  core reports the device is configured.
- buf_out_hasdata  in  1  OUT buffer holds an unread packet.
- buf_out_len  in  LEN_W  byte count of the held OUT packet.
- buf_out_addr  out  ADDR_W  OUT buffer read address.
- buf_out_q  in  8  OUT buffer read data; 1-cycle latency from buf_out_addr.
- buf_out_arm  out  1  release OUT buffer to the core; level request.
- buf_out_arm_ack  in  1  core accepted the arm.
- buf_in_ready  in  1  IN buffer free for writing.
- buf_in_addr  out  ADDR_W  IN buffer write address.
- buf_in_data  out  8  IN buffer write data.
- buf_in_wren  out  1  IN buffer write strobe.
- buf_in_commit  out  1  hand the IN packet to the core; level request.
- buf_in_commit_len  out  LEN_W  committed length.
- buf_in_commit_ack  in  1  core accepted the commit.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values: every output is 0; state is IDLE; the address and length registers are 0.
- IDLE -> WAIT_IN when enable & stat_configured & buf_out_hasdata.
  - On this transition, latch len = min(buf_out_len, MAX_LEN).
  - Set buf_out_addr = 0.
- WAIT_IN -> COPY when buf_in_ready = 1.
  - The OUT packet is never read until the IN buffer is free.
- COPY:
  - Read counter rd increments every cycle while rd < len, and drives buf_out_addr.
  - The write side is rd delayed by 1 cycle: buf_in_wren = 1 with buf_in_addr = rd_d and buf_in_data = buf_out_q.
  - Copying len bytes takes len+1 cycles, with exactly len wren pulses at addresses 0..len-1 in order.
  - After the final write, go to COMMIT.
- len = 0 (zero-length packet): go from WAIT_IN straight to COMMIT, with no reads and no wren.
- COMMIT:
  - Hold buf_in_commit = 1 and buf_in_commit_len = len until the cycle buf_in_commit_ack = 1.
  - In that cycle deassert commit and go to ARM.
- ARM:
  - Hold buf_out_arm = 1 until buf_out_arm_ack = 1.
  - Then deassert it and return to IDLE.
  - Next earliest start is the following cycle.
- Clamping: a buf_out_len of 513-1023 yields exactly 512 bytes copied and commit_len = 512.
- The rd counter is LEN_W wide, so reaching 512 does not wrap; buf_out_addr uses rd[ADDR_W-1:0].
- stat_configured falling in any non-IDLE state:
  - Synchronously abort to IDLE and drop every request.
  - No commit or arm is issued; the core's own reset flushes its buffers.
- enable falling mid-packet is ignored; the packet completes.
- An ack that arrives together with its request is accepted in the same cycle.
- An ack seen outside its state is ignored.
- Asynchronous reset asserted mid-operation forces IDLE immediately, with all outputs 0.

Optional Feature:
- Macro USB2_LOOPBACK_STATS_EN.
- With it defined, add two outputs:
  - stat_pkt_cnt [15:0]: increments on each commit_ack.
  - stat_byte_cnt [31:0]: adds len on each commit_ack.
  - Both wrap modulo 2^width, reset to 0, and are not cleared by an abort.
- Without it, these ports and registers do not exist.

Decomposition:
- Shared package usb2_pkg holds:
  - The state encoding (IDLE, WAIT_IN, COPY, COMMIT, ARM).
  - USB2_BUF_ADDR_W = 9, USB2_BUF_LEN_W = 10, USB2_MAX_PKT = 512.
- No sub-module; the single FSM plus copy datapath stays in one module.

Test Plan:
- 64-byte OUT packet of pattern 0x00..0x3F, buf_in_ready = 1 -> 64 wren pulses at addresses 0..63 with matching data, commit_len = 64, then one arm after the commit_ack; busy for 64+1+ack cycles.
- Zero-length OUT packet -> no wren, commit_len = 0, then arm; back to IDLE.
- buf_out_len = 700 -> 512 writes, the last at address 511, commit_len = 512.
- buf_in_ready held 0 for 20 cycles after hasdata -> buf_out_addr stays 0 and there is no wren; copy starts the cycle after ready rises.
- commit_ack delayed 10 cycles, then arm_ack delayed 5 cycles -> commit and arm each held steady for the full wait, never both high together.
- stat_configured drops midway through COPY of 100 bytes -> IDLE the next cycle, no commit or arm issued; with USB2_LOOPBACK_STATS_EN, two completed 10-byte packets give pkt_cnt = 2 and byte_cnt = 20.
